// File: rtl/dynamic_obst_ctl.sv
// dynamic_obst_ctl: bounces the dynamic obstacle between X_MIN and X_MAX-WIDTH.
// Position updates only on the rising edge of vblank_in, so a frame is never
// drawn with a half-updated position. The obstacle pauses at each bound.
//
// Handshake: there is none. vblank_in is a level from the timing chain.
// restart is a one-cycle pulse that is accepted on any cycle it is high.
// enable is a level; while it is low all motion state holds.
module dynamic_obst_ctl #(
    parameter int X_MIN           = 100,
    parameter int X_MAX           = 700,
    parameter int WIDTH           = 50,
    parameter int Y_POS           = 150,
    parameter int STEP            = 4,
    parameter int FRAMES_PER_STEP = 1,
    parameter int DWELL_FRAMES    = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblank_in,
    input  logic        enable,
    input  logic        restart,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        dir_right,
    output logic        dwelling,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        MOVE_R  = 2'd0,
        DWELL_R = 2'd1,
        MOVE_L  = 2'd2,
        DWELL_L = 2'd3
    } state_t;

    // Bounds and counter limits, widened to 13 bits so x_pos + STEP cannot wrap.
    localparam logic [12:0] X_RIGHT     = 13'(X_MAX - WIDTH);
    localparam logic [12:0] X_LEFT_TRIG = 13'(X_MIN + STEP);
    localparam logic [12:0] STEP_13     = 13'(STEP);
    localparam logic [11:0] STEP_12     = 12'(STEP);
    localparam logic [11:0] X_MIN_12    = 12'(X_MIN);
    localparam logic [7:0]  STEP_LAST   = 8'(FRAMES_PER_STEP - 1);
    localparam int          DWELL_LAST_I = (DWELL_FRAMES > 0) ? DWELL_FRAMES - 1 : 0;
    localparam logic [7:0]  DWELL_LAST  = 8'(DWELL_LAST_I);
    localparam bit          HAS_DWELL   = (DWELL_FRAMES > 0);

    state_t      state, state_n;
    logic        vblank_d;
    logic        tick;
    logic [7:0]  step_cnt, step_cnt_n;
    logic [7:0]  dwell_cnt, dwell_cnt_n;
    logic [11:0] x_n;
    logic [12:0] x_ext, x_up;
    logic        dir_right_n, dwelling_n;

    assign tick      = vblank_in & ~vblank_d;
    assign y_pos     = 12'(Y_POS);
    assign state_dbg = state;
    assign x_ext     = {1'b0, x_pos};
    assign x_up      = x_ext + STEP_13;

    // Next-state, position and counter logic; everything holds unless an enabled tick arrives.
    always_comb begin
        state_n     = state;
        x_n         = x_pos;
        step_cnt_n  = step_cnt;
        dwell_cnt_n = dwell_cnt;
        if (tick && enable) begin
            case (state)
                MOVE_R: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_n = 8'd0;
                        if (x_up >= X_RIGHT) begin
                            x_n     = X_RIGHT[11:0];
                            state_n = HAS_DWELL ? DWELL_R : MOVE_L;
                        end else begin
                            x_n = x_up[11:0];
                        end
                    end else begin
                        step_cnt_n = step_cnt + 8'd1;
                    end
                end
                MOVE_L: begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_n = 8'd0;
                        if (x_ext <= X_LEFT_TRIG) begin
                            x_n     = X_MIN_12;
                            state_n = HAS_DWELL ? DWELL_L : MOVE_R;
                        end else begin
                            x_n = x_pos - STEP_12;
                        end
                    end else begin
                        step_cnt_n = step_cnt + 8'd1;
                    end
                end
                DWELL_R: begin
                    step_cnt_n = 8'd0;
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt_n = 8'd0;
                        state_n     = MOVE_L;
                    end else begin
                        dwell_cnt_n = dwell_cnt + 8'd1;
                    end
                end
                default: begin
                    step_cnt_n = 8'd0;
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt_n = 8'd0;
                        state_n     = MOVE_R;
                    end else begin
                        dwell_cnt_n = dwell_cnt + 8'd1;
                    end
                end
            endcase
        end
        dir_right_n = (state_n == MOVE_R) || (state_n == DWELL_L);
        dwelling_n  = (state_n == DWELL_R) || (state_n == DWELL_L);
    end

    // State register; restart returns to the reset state like rst does.
    always_ff @(posedge pclk) begin
        if (rst || restart) begin
            state <= MOVE_R;
        end else begin
            state <= state_n;
        end
    end

    // vblank delay tracks even while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblank_d <= 1'b0;
        end else begin
            vblank_d <= vblank_in;
        end
    end

    // Position, counters and status outputs, registered alongside the state.
    always_ff @(posedge pclk) begin
        if (rst || restart) begin
            x_pos     <= X_MIN_12;
            step_cnt  <= 8'd0;
            dwell_cnt <= 8'd0;
            dir_right <= 1'b1;
            dwelling  <= 1'b0;
        end else begin
            x_pos     <= x_n;
            step_cnt  <= step_cnt_n;
            dwell_cnt <= dwell_cnt_n;
            dir_right <= dir_right_n;
            dwelling  <= dwelling_n;
        end
    end

endmodule

// File: tb/tb_dynamic_obst_ctl.sv
// Bench for dynamic_obst_ctl: a default instance and one with FRAMES_PER_STEP=3,
// DWELL_FRAMES=0. A behavioural position model feeds an expected queue of
// {dwelling, dir_right, x_pos}; each tick's result is popped and compared.
module tb_dynamic_obst_ctl;

    localparam int X_L = 100;
    localparam int X_R = 650;

    // clock / reset / stimulus signals
    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic vblank_in = 1'b0;
    logic enable = 1'b1;
    logic restart = 1'b0;

    logic [11:0] x_a, y_a, x_b, y_b;
    logic        dr_a, dw_a, dr_b, dw_b;
    logic [1:0]  st_a, st_b;
    logic        use_b = 1'b0;
    logic [13:0] obs;

    int checks = 0;
    int failures = 0;
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;

    // model state
    int m_x, m_sc, m_dc, m_fps, m_dwf;
    bit m_dir, m_dw;

    always #5 pclk = ~pclk;

    assign obs = use_b ? {dw_b, dr_b, x_b} : {dw_a, dr_a, x_a};

    dynamic_obst_ctl dut_a (
        .pclk(pclk), .rst(rst), .vblank_in(vblank_in), .enable(enable), .restart(restart),
        .x_pos(x_a), .y_pos(y_a), .dir_right(dr_a), .dwelling(dw_a), .state_dbg(st_a)
    );

    dynamic_obst_ctl #(.FRAMES_PER_STEP(3), .DWELL_FRAMES(0)) dut_b (
        .pclk(pclk), .rst(rst), .vblank_in(vblank_in), .enable(enable), .restart(restart),
        .x_pos(x_b), .y_pos(y_b), .dir_right(dr_b), .dwelling(dw_b), .state_dbg(st_b)
    );

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_x = X_L; m_dir = 1'b1; m_dw = 1'b0; m_sc = 0; m_dc = 0;
        last_exp = {1'b0, 1'b1, 12'(X_L)};
    endtask

    task automatic model_tick();
        if (m_dw) begin
            m_dc++;
            if (m_dc == m_dwf) begin
                m_dc = 0;
                m_dw = 1'b0;
            end
        end else begin
            m_sc++;
            if (m_sc == m_fps) begin
                m_sc = 0;
                if (m_dir) begin
                    if (m_x + 4 >= X_R) begin
                        m_x = X_R; m_dir = 1'b0; m_dw = (m_dwf > 0);
                    end else begin
                        m_x += 4;
                    end
                end else begin
                    if (m_x <= X_L + 4) begin
                        m_x = X_L; m_dir = 1'b1; m_dw = (m_dwf > 0);
                    end else begin
                        m_x -= 4;
                    end
                end
            end
        end
    endtask

    // driver: one vblank pulse, optionally with a coinciding restart
    task automatic send_tick(input bit rs);
        logic [13:0] e;
        @(negedge pclk);
        vblank_in = 1'b1;
        restart = rs;
        check("pre_edge_hold", 32'(obs), 32'(last_exp));
        if (rs) model_reset();
        else if (enable) model_tick();
        exp_q.push_back({m_dw, m_dir, 12'(m_x)});
        @(posedge pclk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            check("tick_out", 32'(obs), 32'(e));
            last_exp = e;
        end
        @(negedge pclk);
        restart = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge pclk);
        vblank_in = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check("fall_hold", 32'(obs), 32'(last_exp));
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) send_tick(1'b0);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        model_reset();
        check("rst_x", 32'(obs[11:0]), 32'(X_L));
        check("rst_dir", 32'(obs[12]), 32'(1));
        check("rst_dwell", 32'(obs[13]), 32'(0));
        check("rst_y_a", 32'(y_a), 32'(150));
        check("rst_y_b", 32'(y_b), 32'(150));
    endtask

    task automatic pulse_restart();
        @(negedge pclk);
        restart = 1'b1;
        model_reset();
        @(posedge pclk);
        #1;
        check("restart_x", 32'(obs), 32'(last_exp));
        @(negedge pclk);
        restart = 1'b0;
    endtask

    initial begin
        // default instance
        use_b = 1'b0; m_fps = 1; m_dwf = 30;
        do_reset();
        check("rst_state", 32'(st_a), 32'(0));
        send_ticks(3);
        check("x_after_3", 32'(x_a), 32'(112));
        send_ticks(134);
        check("x_after_137", 32'(x_a), 32'(648));
        send_ticks(1);
        check("clamp_r_x", 32'(x_a), 32'(650));
        check("clamp_r_dwell", 32'(dw_a), 32'(1));
        check("clamp_r_dir", 32'(dr_a), 32'(0));
        check("clamp_r_state", 32'(st_a), 32'(1));
        send_ticks(30);
        check("dwell_r_hold_x", 32'(x_a), 32'(650));
        send_ticks(1);
        check("x_after_169", 32'(x_a), 32'(646));
        send_ticks(136);
        check("x_left_102", 32'(x_a), 32'(102));
        send_ticks(1);
        check("clamp_l_x", 32'(x_a), 32'(100));
        check("clamp_l_dwell", 32'(dw_a), 32'(1));
        send_ticks(30);
        check("dwell_l_exit_dir", 32'(dr_a), 32'(1));
        check("dwell_l_exit_dwell", 32'(dw_a), 32'(0));
        send_ticks(1);
        check("resume_104", 32'(x_a), 32'(104));

        // enable freeze at 300
        pulse_restart();
        send_ticks(50);
        check("x_at_300", 32'(x_a), 32'(300));
        enable = 1'b0;
        send_ticks(5);
        check("frozen_300", 32'(x_a), 32'(300));
        enable = 1'b1;
        send_ticks(1);
        check("reenable_304", 32'(x_a), 32'(304));

        // restart coinciding with a tick while in DWELL_R
        send_ticks(87);
        send_ticks(2);
        check("pre_restart_dwell", 32'(dw_a), 32'(1));
        send_tick(1'b1);
        check("restart_tick_x", 32'(x_a), 32'(100));
        check("restart_tick_dir", 32'(dr_a), 32'(1));
        check("restart_tick_dwell", 32'(dw_a), 32'(0));
        send_ticks(1);
        check("after_restart_104", 32'(x_a), 32'(104));

        // FRAMES_PER_STEP = 3, DWELL_FRAMES = 0
        use_b = 1'b1; m_fps = 3; m_dwf = 0;
        do_reset();
        send_ticks(2);
        check("b_no_step_yet", 32'(x_b), 32'(100));
        send_ticks(1);
        check("b_first_step", 32'(x_b), 32'(104));
        send_ticks(411);
        check("b_clamp_x", 32'(x_b), 32'(650));
        check("b_clamp_dir", 32'(dr_b), 32'(0));
        check("b_clamp_dwell", 32'(dw_b), 32'(0));
        send_ticks(2);
        check("b_hold_650", 32'(x_b), 32'(650));
        send_ticks(1);
        check("b_back_646", 32'(x_b), 32'(646));
        check("b_y_const", 32'(y_b), 32'(150));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
